// File: rtl/fifo_fwft_if.sv
// Producer/consumer handshake bundle for fifo_fwft: write/read requests, data and status flags.
interface fifo_fwft_if #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 4
);
    logic         flush;
    logic         WE;
    logic [W-1:0] data_in;
    logic         RE;
    logic [W-1:0] data_out;
    logic         valid;
    logic         empty;
    logic         full;
    logic         almost_full;
    logic         almost_empty;
    logic [N:0]   count;
    logic         overflow;
    logic         underflow;

    modport master (
        output flush, WE, data_in, RE,
        input  data_out, valid, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, WE, data_in, RE,
        output data_out, valid, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_fwft.sv
// Single-clock FIFO using all 2^N entries, with occupancy count, programmable almost flags,
// sticky error flags and a selectable first-word-fall-through or registered read port.
module fifo_fwft #(
    parameter int unsigned W         = 8,
    parameter int unsigned N         = 4,
    parameter int unsigned AF_THRESH = (2 ** N) - 2,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned FWFT      = 1
) (
    input  logic      r_clk,
    input  logic      reset,
    fifo_fwft_if.slave bus
);
    localparam int unsigned AW    = N;
    localparam int unsigned CW    = N + 1;
    localparam int unsigned DEPTH = 2 ** N;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] r_addr_q, r_addr_d;
    logic [AW-1:0] w_addr_q, w_addr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          full_c, empty_c, wr_acc_c, rd_acc_c;

    assign full_c  = (count_q == FULL_C);
    assign empty_c = (count_q == '0);

    // Flush wins over both requests; error flags only record attempts on non-flush cycles.
    always_comb begin
        r_addr_d    = r_addr_q;
        w_addr_d    = w_addr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        dout_d      = dout_q;
        valid_d     = 1'b0;
        wr_acc_c    = 1'b0;
        rd_acc_c    = 1'b0;
        if (bus.flush) begin
            r_addr_d    = '0;
            w_addr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            wr_acc_c = bus.WE && !full_c;
            rd_acc_c = bus.RE && !empty_c;
            if (bus.WE && full_c)  overflow_d  = 1'b1;
            if (bus.RE && empty_c) underflow_d = 1'b1;
            if (wr_acc_c) w_addr_d = AW'(w_addr_q + 1'b1);
            if (rd_acc_c) begin
                r_addr_d = AW'(r_addr_q + 1'b1);
                dout_d   = mem[r_addr_q];
                valid_d  = 1'b1;
            end
            unique case ({wr_acc_c, rd_acc_c})
                2'b10:   count_d = CW'(count_q + 1'b1);
                2'b01:   count_d = CW'(count_q - 1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge r_clk or negedge reset) begin
        if (!reset) begin
            r_addr_q    <= '0;
            w_addr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            r_addr_q    <= r_addr_d;
            w_addr_q    <= w_addr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge r_clk) begin
        if (wr_acc_c) mem[w_addr_q] <= bus.data_in;
    end

    assign bus.data_out     = (FWFT != 0) ? mem[r_addr_q] : dout_q;
    assign bus.valid        = (FWFT != 0) ? !empty_c : valid_q;
    assign bus.empty        = empty_c;
    assign bus.full         = full_c;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
